// File: rtl/rv_pkg.sv
// Shared constants for the rv datapath slice: ALU operation codes, opcodes, widths.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int IMM_W = 12;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP     = 7'h33;

endpackage

// File: rtl/rv_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 has no storage and always reads zero.
module rv_regfile
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs [32];

  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [XLEN-1:0] reg_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else if (we_i && (waddr_i == 5'(gi))) begin
          reg_q <= wdata_i;
        end
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

  assign rdata_a_o = regs[raddr_a_i];
  assign rdata_b_o = regs[raddr_b_i];

endmodule

// File: rtl/rv_datapath.sv
// Multi-cycle RV32I datapath: PC, IR, A/B operand latches, ALU with F latch, register file.
// Optional macro RV_DATAPATH_FLAGS_EN adds a registered {ZF,SF,CF,OF} flags output.
module rv_datapath
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        IR_Write,
  input  logic        Reg_Write,
  input  logic        rs2_imm_s,
  input  logic        w_data_s,
  input  logic [3:0]  ALU_OP,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_addr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] alu_f
`ifdef RV_DATAPATH_FLAGS_EN
 ,output logic [3:0]  flags
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] a_q, b_q, f_q, f_d;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] imm_i, imm_u;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rd, rs1, rs2, shamt;
  logic            rf_we;

  assign rd  = ir_q[11:7];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];

  assign imm_i = {{(XLEN-IMM_W){ir_q[31]}}, ir_q[31:XLEN-IMM_W]};
  assign imm_u = {ir_q[31:12], 12'b0};

  assign op_a  = a_q;
  assign op_b  = rs2_imm_s ? imm_i : b_q;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (ALU_OP)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (PC_Write) pc_d = pc_q + 32'd4;
    if (IR_Write) ir_d = inst_rdata;
    f_d = alu_res;
  end

  // rd/rs come from the pre-edge IR, so a coincident IR load never retargets the write.
  assign wb_data = w_data_s ? imm_u : f_q;
  assign rf_we   = Reg_Write && (rd != 5'd0);

  rv_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (wb_data),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= rf_a;
      b_q  <= rf_b;
      f_q  <= f_d;
    end
  end

`ifdef RV_DATAPATH_FLAGS_EN
  logic [XLEN:0] add_ext, sub_ext;
  logic [3:0]    flags_q, flags_d;

  // Bit XLEN of the subtract is the borrow (set when op_a < op_b unsigned).
  assign add_ext = {1'b0, op_a} + {1'b0, op_b};
  assign sub_ext = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    flags_d    = 4'b0;
    flags_d[3] = (alu_res == '0);
    flags_d[2] = alu_res[XLEN-1];
    if (ALU_OP == ALU_ADD) begin
      flags_d[1] = add_ext[XLEN];
      flags_d[0] = (op_a[XLEN-1] == op_b[XLEN-1]) && (add_ext[XLEN-1] != op_a[XLEN-1]);
    end else if (ALU_OP == ALU_SUB) begin
      flags_d[1] = sub_ext[XLEN];
      flags_d[0] = (op_a[XLEN-1] != op_b[XLEN-1]) && (sub_ext[XLEN-1] != op_a[XLEN-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

  assign inst_addr = pc_q;
  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign alu_f     = f_q;

endmodule

// File: tb/tb_rv_datapath.sv
// Directed self-checking bench for rv_datapath; RESET_PC is set just below the
// 32-bit wrap point so that PC overflow is reachable in a few cycles.
module tb_rv_datapath;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_Write, IR_Write, Reg_Write, rs2_imm_s, w_data_s;
  logic [3:0]  ALU_OP;
  logic [31:0] inst_rdata;
  logic [31:0] inst_addr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] alu_f;
`ifdef RV_DATAPATH_FLAGS_EN
  logic [3:0]  flags;
`endif

  int errors = 0;
  int checks = 0;

  rv_datapath #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC_Write   (PC_Write),
    .IR_Write   (IR_Write),
    .Reg_Write  (Reg_Write),
    .rs2_imm_s  (rs2_imm_s),
    .w_data_s   (w_data_s),
    .ALU_OP     (ALU_OP),
    .inst_rdata (inst_rdata),
    .inst_addr  (inst_addr),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .alu_f      (alu_f)
`ifdef RV_DATAPATH_FLAGS_EN
   ,.flags      (flags)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    inst_rdata = instr;
    IR_Write   = 1'b1;
    step();
    IR_Write   = 1'b0;
  endtask

  // Executes an I-type instruction: A latch, then F, then optional write-back of F.
  task automatic run_i(input logic [31:0] instr, input logic [3:0] op, input bit wr);
    load_ir(instr);
    rs2_imm_s = 1'b1;
    ALU_OP    = op;
    step();
    step();
    if (wr) begin
      w_data_s  = 1'b0;
      Reg_Write = 1'b1;
      step();
      Reg_Write = 1'b0;
    end
  endtask

  // Reads x[r] into F via addi x0, x[r], 0.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    load_ir({12'd0, r, 3'b000, 5'd0, 7'h13});
    rs2_imm_s = 1'b1;
    ALU_OP    = 4'b0000;
    step();
    step();
    v = alu_f;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (inst_addr !== RST_PC || opcode !== 7'h0 || funct3 !== 3'h0 ||
        funct7 !== 7'h0 || alu_f !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: pc=%h op=%h f3=%h f7=%h f=%h", inst_addr, opcode, funct3, funct7, alu_f);
    end
    $display("reset_state: pc=%h f=%h", inst_addr, alu_f);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    run_i(32'h0070_0293, 4'b0000, 1'b1);
    read_reg(5'd5, v);
    checks++;
    if (v !== 32'd7) begin
      errors++;
      $display("FAIL x5_before_reset: got %h want %h", v, 32'd7);
    end
    $display("x5_before_reset: %h", v);
    PC_Write = 1'b1;
    step();
    PC_Write = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_addr !== RST_PC || alu_f !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: pc=%h want %h f=%h want 0", inst_addr, RST_PC, alu_f);
    end
    $display("async_reset: pc=%h f=%h", inst_addr, alu_f);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    read_reg(5'd5, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL x5_after_reset: got %h want 0", v);
    end
    $display("x5_after_reset: %h", v);
  endtask

  task automatic test_fetch();
    logic [31:0] v;
    inst_rdata = 32'h00A0_0293;
    IR_Write   = 1'b1;
    PC_Write   = 1'b1;
    step();
    IR_Write   = 1'b0;
    PC_Write   = 1'b0;
    checks++;
    if (opcode !== 7'h13 || funct3 !== 3'h0 || inst_addr !== RST_PC + 32'd4) begin
      errors++;
      $display("FAIL fetch: op=%h f3=%h pc=%h want op=13 f3=0 pc=%h", opcode, funct3, inst_addr, RST_PC + 32'd4);
    end
    $display("fetch: op=%h pc=%h", opcode, inst_addr);
    rs2_imm_s = 1'b1;
    ALU_OP    = 4'b0000;
    step();
    step();
    checks++;
    if (alu_f !== 32'd10) begin
      errors++;
      $display("FAIL addi_f: got %h want %h", alu_f, 32'd10);
    end
    $display("addi_f: %h", alu_f);
    w_data_s  = 1'b0;
    Reg_Write = 1'b1;
    step();
    Reg_Write = 1'b0;
    read_reg(5'd5, v);
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL addi_x5: got %h want %h", v, 32'd10);
    end
    $display("addi_x5: %h", v);
  endtask

  task automatic test_wrap();
    PC_Write = 1'b1;
    step();
    checks++;
    if (inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got %h want 0", inst_addr);
    end
    $display("pc_wrap: %h", inst_addr);
    step();
    PC_Write = 1'b0;
    checks++;
    if (inst_addr !== 32'h4) begin
      errors++;
      $display("FAIL pc_after_wrap: got %h want 4", inst_addr);
    end
    $display("pc_after_wrap: %h", inst_addr);
  endtask

  task automatic test_shift();
    logic [31:0] v;
    load_ir(32'h8000_0337);
    w_data_s  = 1'b1;
    Reg_Write = 1'b1;
    step();
    Reg_Write = 1'b0;
    w_data_s  = 1'b0;
    read_reg(5'd6, v);
    checks++;
    if (v !== 32'h8000_0000) begin
      errors++;
      $display("FAIL lui_x6: got %h want 80000000", v);
    end
    $display("lui_x6: %h", v);
    run_i(32'h4043_5393, 4'b1101, 1'b1);
    checks++;
    if (funct7 !== 7'h20 || funct3 !== 3'h5) begin
      errors++;
      $display("FAIL srai_fields: f7=%h f3=%h want 20 5", funct7, funct3);
    end
    read_reg(5'd7, v);
    checks++;
    if (v !== 32'hF800_0000) begin
      errors++;
      $display("FAIL srai_x7: got %h want f8000000", v);
    end
    $display("srai_x7: %h", v);
    run_i(32'h4043_5393, 4'b0101, 1'b0);
    checks++;
    if (alu_f !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srli_f: got %h want 08000000", alu_f);
    end
    $display("srli_f: %h", alu_f);
  endtask

  task automatic test_lui();
    logic [31:0] v;
    load_ir(32'h1234_5437);
    w_data_s  = 1'b1;
    Reg_Write = 1'b1;
    step();
    Reg_Write = 1'b0;
    w_data_s  = 1'b0;
    read_reg(5'd8, v);
    checks++;
    if (v !== 32'h1234_5000) begin
      errors++;
      $display("FAIL lui_x8: got %h want 12345000", v);
    end
    $display("lui_x8: %h", v);
  endtask

  // R-type with A = x6 = 80000000, B = x5 = 0000000a.
  task automatic test_alu_ops();
    logic [3:0]  ops [12];
    logic [31:0] exp [12];
    ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111, 4'b1001};
    exp = '{32'h8000_000A, 32'h7FFF_FFF6, 32'h0000_0000, 32'h0000_0001,
            32'h0000_0000, 32'h8000_000A, 32'h0020_0000, 32'hFFE0_0000,
            32'h8000_000A, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    load_ir(32'h0053_0033);
    rs2_imm_s = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      ALU_OP = ops[i];
      step();
      checks++;
      if (alu_f !== exp[i]) begin
        errors++;
        $display("FAIL alu_op_%b: got %h want %h", ops[i], alu_f, exp[i]);
      end
      $display("alu_op_%b: %h", ops[i], alu_f);
`ifdef RV_DATAPATH_FLAGS_EN
      if (i == 0) begin
        checks++;
        if (flags !== 4'b0100) begin
          errors++;
          $display("FAIL flags_add: got %b want 0100", flags);
        end
      end else if (i == 1) begin
        checks++;
        if (flags !== 4'b0001) begin
          errors++;
          $display("FAIL flags_sub: got %b want 0001", flags);
        end
      end
`endif
    end
    rs2_imm_s = 1'b1;
  endtask

  task automatic test_x0();
    logic [31:0] v;
    run_i(32'h0050_0013, 4'b0000, 1'b1);
    checks++;
    if (alu_f !== 32'd5) begin
      errors++;
      $display("FAIL x0_f: got %h want 5", alu_f);
    end
    read_reg(5'd0, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL x0_stays_zero: got %h want 0", v);
    end
    $display("x0_stays_zero: %h", v);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    run_i(32'h0554_8493, 4'b0000, 1'b0);
    checks++;
    if (alu_f !== 32'h55) begin
      errors++;
      $display("FAIL b2b_setup: got %h want 55", alu_f);
    end
    inst_rdata = 32'h0004_8533;
    w_data_s   = 1'b0;
    Reg_Write  = 1'b1;
    IR_Write   = 1'b1;
    step();
    Reg_Write  = 1'b0;
    IR_Write   = 1'b0;
    checks++;
    if (opcode !== 7'h33) begin
      errors++;
      $display("FAIL b2b_ir: got %h want 33", opcode);
    end
    step();
    checks++;
    if (alu_f !== 32'h0) begin
      errors++;
      $display("FAIL b2b_old_value: got %h want 0", alu_f);
    end
    $display("b2b_old_value: %h", alu_f);
    step();
    checks++;
    if (alu_f !== 32'h55) begin
      errors++;
      $display("FAIL b2b_new_value: got %h want 55", alu_f);
    end
    $display("b2b_new_value: %h", alu_f);
    read_reg(5'd10, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL b2b_new_rd_untouched: got %h want 0", v);
    end
    read_reg(5'd9, v);
    checks++;
    if (v !== 32'h55) begin
      errors++;
      $display("FAIL b2b_old_rd_written: got %h want 55", v);
    end
    $display("b2b_x9: %h", v);
  endtask

  initial begin
    rst_n      = 1'b0;
    PC_Write   = 1'b0;
    IR_Write   = 1'b0;
    Reg_Write  = 1'b0;
    rs2_imm_s  = 1'b0;
    w_data_s   = 1'b0;
    ALU_OP     = 4'b0000;
    inst_rdata = 32'h0;
    test_reset();
    test_fetch();
    test_wrap();
    test_shift();
    test_lui();
    test_alu_ops();
    test_x0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_datapath.md
RV_DATAPATH -- requirements
Module: rv_datapath

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PC_Write  input  1  PC advance strobe from control unit.
REQ-005 SHALL have port IR_Write  input  1  instruction register load strobe.
REQ-006 SHALL have port Reg_Write  input  1  register file write strobe.
REQ-007 SHALL have port rs2_imm_s  input  1  ALU B select: 0 = B latch, 1 = immediate.
REQ-008 SHALL have port w_data_s  input  1  write-back select: 0 = F latch, 1 = U-immediate.
REQ-009 SHALL have port ALU_OP  input  4  ALU operation code.
REQ-010 SHALL have port inst_rdata  input  32  instruction memory read data.
REQ-011 SHALL have port inst_addr  output  32  instruction fetch address, equal to PC.
REQ-012 SHALL have port opcode  output  7  IR[6:0].
REQ-013 SHALL have port funct3  output  3  IR[14:12].
REQ-014 SHALL have port funct7  output  7  IR[31:25].
REQ-015 SHALL have port alu_f  output  32  F latch contents.

Function
REQ-016 SHALL load IR <= inst_rdata on a clk edge where IR_Write=1; otherwise IR holds.
REQ-017 SHALL update PC <= PC + 4 (mod 2^32) on a clk edge where PC_Write=1; 32'hFFFF_FFFC wraps to 0.
REQ-018 SHALL load A <= x[IR[19:15]] and B <= x[IR[24:20]] on every clk edge; x0 always reads 0.
REQ-019 SHALL load F <= ALU result on every clk edge.
REQ-020 SHALL form I-immediate as sign-extended IR[31:20] and U-immediate as {IR[31:12], 12'b0}.
REQ-021 SHALL use ALU operand A = A latch and operand B = rs2_imm_s ? I-immediate : B latch.
REQ-022 SHALL decode ALU_OP: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and; any other code gives 0.
REQ-023 SHALL use only operand B[4:0] as the shift amount.
REQ-024 SHALL write x[IR[11:7]] <= (w_data_s ? U-immediate : F) on a clk edge where Reg_Write=1 and rd != 0; writes to x0 are discarded.
REQ-025 SHALL use the pre-edge IR for rd, rs1 and rs2 when IR_Write coincides with Reg_Write or A/B loading.
REQ-026 SHALL provide no write-read bypass: A/B return the old value on the write edge and the new value one cycle later.
REQ-027 SHALL give every strobe equal priority, so any combination may assert in one cycle with independent effects.

Reset
REQ-028 SHALL, while rst_n=0, force PC=RESET_PC, IR=0, A=B=F=0 and all x1..x31=0, regardless of clk.
REQ-029 SHALL discard an operation interrupted by reset, with no partial write surviving.
REQ-030 SHALL therefore reset outputs to inst_addr=RESET_PC, opcode=0, funct3=0, funct7=0, alu_f=0.

Configuration
REQ-031 SHALL, when macro RV_DATAPATH_FLAGS_EN is defined, add output flags[3:0] = {ZF,SF,CF,OF}, registered alongside F:
- ZF = result==0
- SF = result[31]
- CF = carry out of add / borrow of sub, else 0
- OF = signed overflow of add/sub, else 0
- reset value 0
REQ-032 SHALL, without RV_DATAPATH_FLAGS_EN, have no flags port and no flag logic.

Structure
REQ-033 SHALL take ALU_OP codes, opcode constants and the immediate width constant from shared package rv_pkg.
REQ-034 SHALL implement the 32x32 register file, with two asynchronous read ports and one synchronous write port, as sub-module rv_regfile.

Verification
REQ-035 SHALL verify reset: rst_n low mid-cycle -> inst_addr=RESET_PC, alu_f=0 immediately; an x5 previously 7 reads 0.
REQ-036 SHALL verify fetch: inst_rdata=32'h00A00293 (addi x5,x0,10) with IR_Write=PC_Write=1 -> opcode=7'h13, PC=4; then rs2_imm_s=1, ALU_OP=0000 -> F=10; then Reg_Write=1 -> x5=10.
REQ-037 SHALL verify arithmetic shift: x6=32'h8000_0000, srai x7,x6,4 with ALU_OP=1101 -> x7=32'hF800_0000; with ALU_OP=0101 -> 32'h0800_0000.
REQ-038 SHALL verify LUI: IR=32'h12345437, w_data_s=1, Reg_Write=1 -> x8=32'h1234_5000.
REQ-039 SHALL verify x0 and wrap: write to rd=0 -> x0 still 0; PC=32'hFFFF_FFFC with PC_Write=1 -> PC=0.
REQ-040 SHALL verify simultaneous strobes: Reg_Write and IR_Write in the same cycle -> the write goes to the old IR's rd; a same-edge read of that register returns the old value, the new value one cycle later.
